pwm_servo_multi: RTL and testbench

- N-channel servo PWM generator. Successor to the single-channel button-driven pwm block.
- Shared period counter drives all channels. Each channel has its own target pulse width and active pulse width.
- Debounced left/right buttons step the target of the currently selected channel. A select button cycles channels.
- Active width slews toward target once per period. Compare values update only at period boundaries, so outputs never glitch.

---
 rtl/pwm_servo_multi.sv | 210 +++++++++++++++++++++
 tb/tb_pwm_servo_multi.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_servo_multi.sv
`default_nettype none
// ============================================================================
// Module      : pwm_servo_multi
// Description : N-channel servo PWM generator with one shared period counter.
//               Each channel keeps a target width (stepped by debounced
//               left/right buttons on the selected channel) and an active
//               width that drives the comparator. Active follows target only
//               at the period boundary, optionally rate-limited by SLEW, so a
//               running pulse is never cut short or stretched.
// Ports       : clk          - system clock
//               rst          - synchronous reset, active-high
//               btn_left     - raw button, decrement target of selected channel
//               btn_right    - raw button, increment target of selected channel
//               btn_sel      - raw button, advance selected channel
//               pwm_out      - registered PWM outputs, one per channel
//               sel_ch       - currently selected channel
//               sel_target   - target width of the selected channel
//               period_start - one-cycle pulse on the first cycle of a period
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_servo_multi #(
    parameter int N_CH      = 4,
    parameter int CNT_W     = 20,
    parameter int PERIOD    = 1000000,
    parameter int MIN_PULSE = 50000,
    parameter int MAX_PULSE = 100000,
    parameter int CENTER    = 75000,
    parameter int STEP      = 5000,
    parameter int SLEW      = 0,
    parameter int DEB_CYC   = 500000,
    localparam int SEL_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             btn_sel,
    output logic [N_CH-1:0]  pwm_out,
    output logic [SEL_W-1:0] sel_ch,
    output logic [CNT_W-1:0] sel_target,
    output logic             period_start
);

    localparam int DEB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

    localparam logic [CNT_W-1:0] c_PERIOD_LAST = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] c_CENTER      = CNT_W'(CENTER);
    localparam logic [CNT_W-1:0] c_MIN         = CNT_W'(MIN_PULSE);
    localparam logic [CNT_W-1:0] c_MAX         = CNT_W'(MAX_PULSE);
    localparam logic [CNT_W-1:0] c_SLEW        = CNT_W'(SLEW);
    localparam logic [CNT_W:0]   c_STEP_W      = (CNT_W+1)'(STEP);
    localparam logic [CNT_W:0]   c_MIN_W       = (CNT_W+1)'(MIN_PULSE);
    localparam logic [CNT_W:0]   c_MAX_W       = (CNT_W+1)'(MAX_PULSE);
    localparam logic [DEB_W-1:0] c_DEB_LAST    = DEB_W'(DEB_CYC - 1);
    localparam logic [SEL_W-1:0] c_SEL_LAST    = SEL_W'(N_CH - 1);

    // ------------------------------------------------------------------------
    // Button conditioning: bit 0 = left, bit 1 = right, bit 2 = select
    // ------------------------------------------------------------------------
    logic [2:0] w_btn_raw;
    logic [2:0] w_btn_evt;

    assign w_btn_raw = {btn_sel, btn_right, btn_left};

    for (genvar b = 0; b < 3; b++) begin : g_btn
        logic             r_sync_meta;
        logic             r_sync;
        logic             r_deb;
        logic             r_evt;
        logic [DEB_W-1:0] r_dcnt;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_sync_meta <= 1'b0;
                r_sync      <= 1'b0;
                r_deb       <= 1'b0;
                r_evt       <= 1'b0;
                r_dcnt      <= '0;
            end else begin
                r_sync_meta <= w_btn_raw[b];
                r_sync      <= r_sync_meta;
                r_evt       <= 1'b0;
                if (r_sync == r_deb) begin
                    // Agreement (or a bounce back) restarts the stability run.
                    r_dcnt <= '0;
                end else if (r_dcnt == c_DEB_LAST) begin
                    // Differing level has now held for DEB_CYC cycles.
                    r_dcnt <= '0;
                    r_deb  <= r_sync;
                    r_evt  <= r_sync;
                end else begin
                    r_dcnt <= r_dcnt + 1'b1;
                end
            end
        end

        assign w_btn_evt[b] = r_evt;
    end

    logic w_evt_left;
    logic w_evt_right;
    logic w_evt_sel;

    assign w_evt_left  = w_btn_evt[0];
    assign w_evt_right = w_btn_evt[1];
    assign w_evt_sel   = w_btn_evt[2];

    // ------------------------------------------------------------------------
    // Period counter and per-channel state
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_target [N_CH];
    logic [CNT_W-1:0] r_active [N_CH];
    logic [CNT_W-1:0] w_next_active [N_CH];
    logic [N_CH-1:0]  r_pwm;
    logic [SEL_W-1:0] r_sel;
    logic             r_period_start;
    logic             w_period_end;

    assign w_period_end = (r_cnt == c_PERIOD_LAST);

    // ------------------------------------------------------------------------
    // Saturating step of the selected target, computed one bit wider so that
    // neither the add nor the subtract can wrap before saturation is applied.
    // ------------------------------------------------------------------------
    logic [CNT_W:0]   w_cur_w;
    logic [CNT_W:0]   w_up_w;
    logic [CNT_W:0]   w_dn_w;
    logic [CNT_W-1:0] w_up_sat;
    logic [CNT_W-1:0] w_dn_sat;
    logic [CNT_W-1:0] w_step_target;
    logic             w_step_en;

    assign w_cur_w = {1'b0, r_target[r_sel]};
    assign w_up_w  = w_cur_w + c_STEP_W;
    assign w_dn_w  = w_cur_w - c_STEP_W;

    always_comb begin
        w_up_sat = c_MAX;
        if (w_up_w <= c_MAX_W) begin
            w_up_sat = w_up_w[CNT_W-1:0];
        end
        w_dn_sat = c_MIN;
        if ((w_cur_w >= c_STEP_W) && (w_dn_w >= c_MIN_W)) begin
            w_dn_sat = w_dn_w[CNT_W-1:0];
        end
    end

    // Simultaneous left and right events cancel.
    assign w_step_en     = w_evt_left ^ w_evt_right;
    assign w_step_target = w_evt_right ? w_up_sat : w_dn_sat;

    // Active value each channel adopts at the next period boundary.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            w_next_active[i] = r_target[i];
            if (SLEW != 0) begin
                if (r_active[i] < r_target[i]) begin
                    if ((r_target[i] - r_active[i]) > c_SLEW) begin
                        w_next_active[i] = r_active[i] + c_SLEW;
                    end
                end else if (r_active[i] > r_target[i]) begin
                    if ((r_active[i] - r_target[i]) > c_SLEW) begin
                        w_next_active[i] = r_active[i] - c_SLEW;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt          <= '0;
            r_pwm          <= '0;
            r_period_start <= 1'b0;
            r_sel          <= '0;
            for (int i = 0; i < N_CH; i++) begin
                r_target[i] <= c_CENTER;
                r_active[i] <= c_CENTER;
            end
        end else begin
            r_cnt          <= w_period_end ? '0 : r_cnt + 1'b1;
            r_period_start <= (r_cnt == '0);

            for (int i = 0; i < N_CH; i++) begin
                r_pwm[i] <= (r_cnt < r_active[i]);
                if (w_period_end) begin
                    r_active[i] <= w_next_active[i];
                end
            end

            // Uses the pre-increment select, so a coinciding step lands on
            // the channel that was selected when the buttons were pressed.
            if (w_step_en) begin
                r_target[r_sel] <= w_step_target;
            end

            if (w_evt_sel) begin
                r_sel <= (r_sel == c_SEL_LAST) ? '0 : r_sel + 1'b1;
            end
        end
    end

    assign pwm_out      = r_pwm;
    assign sel_ch       = r_sel;
    assign sel_target   = r_target[r_sel];
    assign period_start = r_period_start;

endmodule
`default_nettype wire

// File: tb/tb_pwm_servo_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_servo_multi
// Description : Self-checking bench for pwm_servo_multi. Two instances share
//               the button inputs: one with SLEW=0 and one with SLEW=2. A
//               period-level reference model predicts every output cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_servo_multi;

    localparam int N_CH   = 4;
    localparam int CNT_W  = 20;
    localparam int PERIOD = 100;
    localparam int MIN_P  = 10;
    localparam int MAX_P  = 30;
    localparam int CENTER = 20;
    localparam int STEP   = 5;
    localparam int DEB    = 4;
    localparam int SLEW_B = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             bl  = 1'b0;
    logic             br  = 1'b0;
    logic             bs  = 1'b0;
    logic [N_CH-1:0]  pwm_a, pwm_b;
    logic [1:0]       sel_a, sel_b;
    logic [CNT_W-1:0] tgt_a, tgt_b;
    logic             ps_a, ps_b;

    always #5 clk = ~clk;

    pwm_servo_multi #(
        .N_CH(N_CH), .CNT_W(CNT_W), .PERIOD(PERIOD), .MIN_PULSE(MIN_P),
        .MAX_PULSE(MAX_P), .CENTER(CENTER), .STEP(STEP), .SLEW(0), .DEB_CYC(DEB)
    ) u_dut_a (
        .clk(clk), .rst(rst), .btn_left(bl), .btn_right(br), .btn_sel(bs),
        .pwm_out(pwm_a), .sel_ch(sel_a), .sel_target(tgt_a), .period_start(ps_a)
    );

    pwm_servo_multi #(
        .N_CH(N_CH), .CNT_W(CNT_W), .PERIOD(PERIOD), .MIN_PULSE(MIN_P),
        .MAX_PULSE(MAX_P), .CENTER(CENTER), .STEP(STEP), .SLEW(SLEW_B), .DEB_CYC(DEB)
    ) u_dut_b (
        .clk(clk), .rst(rst), .btn_left(bl), .btn_right(br), .btn_sel(bs),
        .pwm_out(pwm_b), .sel_ch(sel_b), .sel_target(tgt_b), .period_start(ps_b)
    );

    int n_err = 0;
    int n_chk = 0;

    // Reference model: position in period, targets, actives, selection.
    int m_c = 0;
    int m_sel = 0;
    int m_tgt   [N_CH];
    int m_act_a [N_CH];
    int m_act_b [N_CH];

    function automatic int slew_to(input int act, input int tgt, input int s);
        if (s == 0) return tgt;
        if (tgt > act) return ((tgt - act) > s) ? act + s : tgt;
        return ((act - tgt) > s) ? act - s : tgt;
    endfunction

    // Cycle monitor: inputs change on negedge, outputs compared 1 time unit
    // after each posedge, then the model advances by one clock.
    always @(posedge clk) begin
        logic            rst_s;
        logic [N_CH-1:0] exp_a, exp_b;
        logic            exp_ps;
        rst_s = rst;
        #1;
        exp_a  = '0;
        exp_b  = '0;
        exp_ps = 1'b0;
        if (!rst_s) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                exp_a[ch] = (m_c < m_act_a[ch]);
                exp_b[ch] = (m_c < m_act_b[ch]);
            end
            exp_ps = (m_c == 0);
        end
        n_chk++;
        assert (pwm_a === exp_a && ps_a === exp_ps) else begin
            n_err++;
            $error("FAIL cyc_a observed pwm=%b ps=%b expected pwm=%b ps=%b (cnt %0d)",
                   pwm_a, ps_a, exp_a, exp_ps, m_c);
        end
        n_chk++;
        assert (pwm_b === exp_b && ps_b === exp_ps) else begin
            n_err++;
            $error("FAIL cyc_b observed pwm=%b ps=%b expected pwm=%b ps=%b (cnt %0d)",
                   pwm_b, ps_b, exp_b, exp_ps, m_c);
        end
        if (rst_s) begin
            m_c   = 0;
            m_sel = 0;
            for (int ch = 0; ch < N_CH; ch++) begin
                m_tgt[ch]   = CENTER;
                m_act_a[ch] = CENTER;
                m_act_b[ch] = CENTER;
            end
        end else if (m_c == PERIOD - 1) begin
            m_c = 0;
            for (int ch = 0; ch < N_CH; ch++) begin
                m_act_a[ch] = slew_to(m_act_a[ch], m_tgt[ch], 0);
                m_act_b[ch] = slew_to(m_act_b[ch], m_tgt[ch], SLEW_B);
            end
        end else begin
            m_c++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // which: 0 left, 1 right, 2 select, 3 left+right together
    task automatic set_btn(input int which, input logic lvl);
        case (which)
            0: bl = lvl;
            1: br = lvl;
            2: bs = lvl;
            default: begin bl = lvl; br = lvl; end
        endcase
    endtask

    // Move to a point early in a period so a whole press finishes well
    // before the next boundary.
    task automatic wait_window();
        int guard = 0;
        do begin @(negedge clk); guard++; end
        while (!(m_c >= 5 && m_c <= 25) && guard < 400);
        chk("window_timeout", (m_c >= 5 && m_c <= 25), 1);
    endtask

    task automatic check_sel();
        chk("sel_ch_a", sel_a, m_sel);
        chk("sel_target_a", tgt_a, m_tgt[m_sel]);
        chk("sel_target_b", tgt_b, m_tgt[m_sel]);
    endtask

    task automatic press(input int which, input bit bounce, input bit nowait);
        if (!nowait) wait_window();
        if (bounce) begin
            for (int k = 0; k < 20; k++) begin
                set_btn(which, ((k / 2) % 2) == 0);
                @(negedge clk);
            end
        end
        set_btn(which, 1'b1);
        repeat (8) @(negedge clk);
        set_btn(which, 1'b0);
        repeat (8) @(negedge clk);
        case (which)
            0: m_tgt[m_sel] = (m_tgt[m_sel] - STEP < MIN_P) ? MIN_P : m_tgt[m_sel] - STEP;
            1: m_tgt[m_sel] = (m_tgt[m_sel] + STEP > MAX_P) ? MAX_P : m_tgt[m_sel] + STEP;
            2: m_sel = (m_sel + 1) % N_CH;
            default: ;
        endcase
        check_sel();
    endtask

    task automatic glitch(input int which, input int len);
        wait_window();
        set_btn(which, 1'b1);
        repeat (len) @(negedge clk);
        set_btn(which, 1'b0);
        repeat (12) @(negedge clk);
        check_sel();
    endtask

    // Count high cycles of one channel over the next full period.
    task automatic measure(input bit use_b, input int ch, output int w);
        int guard = 0;
        w = 0;
        do begin @(negedge clk); guard++; end
        while (ps_a !== 1'b1 && guard < 300);
        chk("period_start_timeout", ps_a, 1);
        for (int k = 0; k < PERIOD; k++) begin
            w += use_b ? int'(pwm_b[ch]) : int'(pwm_a[ch]);
            if (k < PERIOD - 1) @(negedge clk);
        end
    endtask

    initial begin
        int w;
        // Reset
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_pwm", pwm_a, 0);
        chk("rst_ps", ps_a, 0);
        chk("rst_sel", sel_a, 0);
        chk("rst_target", tgt_a, CENTER);
        rst = 1'b0;
        measure(0, 0, w); chk("w_reset_ch0", w, 20);
        measure(0, 3, w); chk("w_reset_ch3", w, 20);

        // Step and saturate on ch0
        press(1, 0, 0); chk("step_25", tgt_a, 25);
        press(1, 0, 0); chk("step_30", tgt_a, 30);
        press(1, 0, 0); chk("step_sat", tgt_a, 30);
        measure(0, 0, w); chk("w_ch0_30", w, 30);
        measure(0, 1, w); chk("w_ch1_20", w, 20);

        // Debounce: bouncy press gives one step, short glitch gives none
        press(0, 0, 0);
        press(0, 0, 0);
        press(1, 1, 0); chk("bounce_one_step", tgt_a, 25);
        glitch(1, 3);   chk("glitch_none", tgt_a, 25);

        // Select and wrap
        press(2, 0, 0); chk("sel_1", sel_a, 1);
        press(2, 0, 0); chk("sel_2", sel_a, 2);
        press(2, 0, 0); chk("sel_3", sel_a, 3);
        press(2, 0, 0); chk("sel_wrap", sel_a, 0);
        press(2, 0, 0);
        press(2, 0, 0);
        press(0, 0, 0); chk("ch2_left", tgt_a, 15);
        measure(0, 2, w); chk("w_ch2_15", w, 15);
        measure(0, 1, w); chk("w_ch1_still", w, 20);
        measure(0, 0, w); chk("w_ch0_still", w, 25);

        // Simultaneous cancel, then minimum saturation
        press(3, 0, 0); chk("both_cancel", tgt_a, 15);
        press(0, 0, 0); chk("min_10", tgt_a, 10);
        press(0, 0, 0); chk("min_sat", tgt_a, 10);

        // Slew on instance b: 20 -> 30 within one period
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        press(1, 0, 0);
        press(1, 0, 1);
        chk("slew_target", tgt_b, 30);
        measure(1, 0, w); chk("slew_22", w, 22);
        measure(1, 0, w); chk("slew_24", w, 24);
        measure(1, 0, w); chk("slew_26", w, 26);
        measure(1, 0, w); chk("slew_28", w, 28);
        measure(1, 0, w); chk("slew_30", w, 30);
        measure(1, 0, w); chk("slew_steady", w, 30);
        press(0, 0, 0);
        press(0, 0, 1);
        measure(1, 0, w); chk("slew_dn_28", w, 28);
        measure(1, 0, w); chk("slew_dn_26", w, 26);
        begin
            int guard = 0;
            while (m_c != 50 && guard < 300) begin @(negedge clk); guard++; end
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        measure(1, 0, w); chk("slew_rst_b", w, 20);
        measure(0, 0, w); chk("slew_rst_a", w, 20);

        // Randomized operations checked against the model
        for (int r = 0; r < 40; r++) begin
            int op;
            op = int'($urandom_range(0, 5));
            if (op == 5) glitch(int'($urandom_range(0, 2)), int'($urandom_range(1, 3)));
            else press(op, bit'($urandom_range(0, 1)), 1'b0);
        end
        repeat (2 * PERIOD) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
